// File: rtl/oam_dma_ctrl_pkg.sv
// Shared constants and state encoding for the sprite-DMA controller.
// OAM_DMA_ALIGN_EN (see oam_dma_ctrl.sv) does not change anything declared here.
package oam_dma_ctrl_pkg;

   localparam int DEFAULT_REG_WIDTH  = 8;
   localparam int DEFAULT_ADDR_WIDTH = 16;

   localparam logic [15:0] OAM_DMA_REG  = 16'h4014;
   localparam logic [15:0] OAM_DATA_REG = 16'h2004;

   localparam logic BUS_OWNER_CPU = 1'b0;
   localparam logic BUS_OWNER_DMA = 1'b1;

   typedef enum logic [2:0] {
      DMA_ST_IDLE  = 3'd0,
      DMA_ST_HALT  = 3'd1,
      DMA_ST_ALIGN = 3'd2,
      DMA_ST_READ  = 3'd3,
      DMA_ST_WRITE = 3'd4
   } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side inputs, muxed memory bus and status of the sprite-DMA controller.
// Handshake: rdy low stalls the CPU; while bus_owner=1 the CPU inputs are ignored by the bus.
interface oam_dma_ctrl_if
   import oam_dma_ctrl_pkg::*;
#(
   parameter int REG_WIDTH  = DEFAULT_REG_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

   logic [ADDR_WIDTH-1:0] cpu_addr;
   logic [REG_WIDTH-1:0]  cpu_data_out;
   logic                  cpu_we;
   logic [REG_WIDTH-1:0]  mem_data_in;

   logic                  rdy;
   logic [ADDR_WIDTH-1:0] bus_addr;
   logic [REG_WIDTH-1:0]  bus_data_out;
   logic                  bus_we;
   logic                  bus_owner;
   logic                  dma_busy;
   logic                  dma_done;

   dma_state_t            dbg_state;
   logic                  dbg_cyc_par;

   modport master (
      input  cpu_addr, cpu_data_out, cpu_we, mem_data_in,
      output rdy, bus_addr, bus_data_out, bus_we, bus_owner,
             dma_busy, dma_done, dbg_state, dbg_cyc_par
   );

   modport slave (
      output cpu_addr, cpu_data_out, cpu_we, mem_data_in,
      input  rdy, bus_addr, bus_data_out, bus_we, bus_owner,
             dma_busy, dma_done, dbg_state, dbg_cyc_par
   );

endinterface

// File: rtl/oam_dma_ctrl_dma_bus_mux.sv
// Owner select of address, write data and write enable between the CPU and the DMA engine.
module dma_bus_mux
   import oam_dma_ctrl_pkg::*;
#(
   parameter int REG_WIDTH  = DEFAULT_REG_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  owner,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [REG_WIDTH-1:0]  cpu_data,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] dma_addr,
   input  logic [REG_WIDTH-1:0]  dma_data,
   input  logic                  dma_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [REG_WIDTH-1:0]  bus_data,
   output logic                  bus_we
);

   assign bus_addr = (owner == BUS_OWNER_DMA) ? dma_addr : cpu_addr;
   assign bus_data = (owner == BUS_OWNER_DMA) ? dma_data : cpu_data;
   assign bus_we   = (owner == BUS_OWNER_DMA) ? dma_we   : cpu_we;

endmodule

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA controller: a CPU write to DMA_REG_ADDR stalls the CPU and copies page $XX00-$XXFF to OAM.
// Define OAM_DMA_ALIGN_EN to insert the odd-cycle ALIGN dummy read (513/514-cycle transfers).
module oam_dma_ctrl
   import oam_dma_ctrl_pkg::*;
#(
   parameter int                    REG_WIDTH     = DEFAULT_REG_WIDTH,
   parameter int                    ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = OAM_DMA_REG,
   parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = OAM_DATA_REG
) (
   input logic            phi1,
   input logic            reset_n,
   oam_dma_ctrl_if.master bus
);

   dma_state_t            state;
   logic                  rdy_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  cyc_par;
   logic [REG_WIDTH-1:0]  page;
   logic [REG_WIDTH-1:0]  idx;
   logic [REG_WIDTH-1:0]  data_buf;
   logic                  trigger;
   logic                  dma_owner;
   logic [ADDR_WIDTH-1:0] dma_addr;

   assign trigger   = bus.cpu_we && (bus.cpu_addr == DMA_REG_ADDR);
   // HALT leaves the CPU on the bus so its in-flight cycle can complete.
   assign dma_owner = (state == DMA_ST_ALIGN) || (state == DMA_ST_READ) ||
                      (state == DMA_ST_WRITE);
   assign dma_addr  = (state == DMA_ST_WRITE) ? OAM_DATA_ADDR : {page, idx};

   always_ff @(posedge phi1) begin
      if (!reset_n) begin
         state    <= DMA_ST_IDLE;
         rdy_q    <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cyc_par  <= 1'b0;
         page     <= '0;
         idx      <= '0;
         data_buf <= '0;
      end else begin
         cyc_par <= ~cyc_par;
         done_q  <= 1'b0;
         case (state)
            DMA_ST_IDLE: begin
               if (trigger) begin
                  page   <= bus.cpu_data_out;
                  idx    <= '0;
                  state  <= DMA_ST_HALT;
                  rdy_q  <= 1'b0;
                  busy_q <= 1'b1;
               end
            end
            DMA_ST_HALT: begin
               if (!bus.cpu_we) begin
`ifdef OAM_DMA_ALIGN_EN
                  // Next cycle odd: burn it so every READ lands on an even cycle.
                  state <= (!cyc_par) ? DMA_ST_ALIGN : DMA_ST_READ;
`else
                  state <= DMA_ST_READ;
`endif
               end
            end
            DMA_ST_ALIGN: state <= DMA_ST_READ;
            DMA_ST_READ: begin
               data_buf <= bus.mem_data_in;
               state    <= DMA_ST_WRITE;
            end
            DMA_ST_WRITE: begin
               if (&idx) begin
                  state  <= DMA_ST_IDLE;
                  rdy_q  <= 1'b1;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= DMA_ST_READ;
               end
            end
            default: begin
               state  <= DMA_ST_IDLE;
               rdy_q  <= 1'b1;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rdy         = rdy_q;
   assign bus.dma_busy    = busy_q;
   assign bus.dma_done    = done_q;
   assign bus.bus_owner   = dma_owner ? BUS_OWNER_DMA : BUS_OWNER_CPU;
   assign bus.dbg_state   = state;
   assign bus.dbg_cyc_par = cyc_par;

   dma_bus_mux #(
      .REG_WIDTH  (REG_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_bus_mux (
      .owner    (dma_owner),
      .cpu_addr (bus.cpu_addr),
      .cpu_data (bus.cpu_data_out),
      .cpu_we   (bus.cpu_we),
      .dma_addr (dma_addr),
      .dma_data (data_buf),
      .dma_we   (state == DMA_ST_WRITE),
      .bus_addr (bus.bus_addr),
      .bus_data (bus.bus_data_out),
      .bus_we   (bus.bus_we)
   );

endmodule
